// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one memory bus between instruction fetch (I) and
// the LSU data port (D). D normally wins. A starvation limiter forces a pending
// fetch ahead after STARVE_MAX consecutive D grants. An in-order ownership FIFO
// routes each memory response back to its requester and restores the D tag.
module riscv_mem_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter int STARVE_MAX  = 4,
  parameter int TAG_W       = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_rd_i,
  input  logic [31:0]      i_pc_i,
  output logic             i_accept_o,
  output logic             i_valid_o,
  output logic             i_error_o,
  output logic [31:0]      i_inst_o,
  input  logic             d_rd_i,
  input  logic [3:0]       d_wr_i,
  input  logic [31:0]      d_addr_i,
  input  logic [31:0]      d_data_wr_i,
  input  logic [TAG_W-1:0] d_req_tag_i,
  output logic             d_accept_o,
  output logic             d_ack_o,
  output logic             d_error_o,
  output logic [31:0]      d_data_rd_o,
  output logic [TAG_W-1:0] d_resp_tag_o,
  output logic             m_rd_o,
  output logic [3:0]       m_wr_o,
  output logic [31:0]      m_addr_o,
  output logic [31:0]      m_data_wr_o,
  input  logic             m_accept_i,
  input  logic             m_ack_i,
  input  logic             m_error_i,
  input  logic [31:0]      m_data_rd_i
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);
  localparam logic [SC_W-1:0]  SMAX     = SC_W'(STARVE_MAX);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOCK_I = 2'd1;
  localparam logic [1:0] LOCK_D = 2'd2;

  typedef struct packed {
    logic             own_d;
    logic [TAG_W-1:0] tag;
  } own_t;

  logic [1:0]       state;
  logic [SC_W-1:0]  starve_cnt;
  own_t             fifo_q [OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic d_req, starve_ovr, full, empty;
  logic gnt_i, gnt_d, drv_i, drv_d, push, pop;
  own_t head, push_ent;

  assign d_req      = d_rd_i | (|d_wr_i);
  assign starve_ovr = i_rd_i & (starve_cnt == SMAX);
  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);

  // Grant selection: a locked requester keeps the bus; otherwise D unless fetch is starved.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    case (state)
      LOCK_I:  gnt_i = 1'b1;
      LOCK_D:  gnt_d = 1'b1;
      default: begin
        if (d_req && !starve_ovr) gnt_d = 1'b1;
        else if (i_rd_i)          gnt_i = 1'b1;
      end
    endcase
  end

  // Nothing is issued while the FIFO is full, even if a pop happens this cycle.
  assign drv_i = gnt_i & ~full & ~rst_i;
  assign drv_d = gnt_d & ~full & ~rst_i;

  assign m_rd_o      = drv_i | (drv_d & d_rd_i);
  assign m_wr_o      = drv_d ? d_wr_i : 4'd0;
  assign m_addr_o    = drv_d ? d_addr_i : (drv_i ? i_pc_i : 32'd0);
  assign m_data_wr_o = drv_d ? d_data_wr_i : 32'd0;

  assign i_accept_o = drv_i & m_accept_i;
  assign d_accept_o = drv_d & m_accept_i;

  assign push           = i_accept_o | d_accept_o;
  assign push_ent.own_d = d_accept_o;
  assign push_ent.tag   = d_accept_o ? d_req_tag_i : '0;

  // Responses arrive in order; an ack with no recorded owner is dropped.
  assign pop  = m_ack_i & ~empty & ~rst_i;
  assign head = fifo_q[rd_ptr];

  assign i_valid_o    = pop & ~head.own_d;
  assign i_error_o    = i_valid_o & m_error_i;
  assign i_inst_o     = i_valid_o ? m_data_rd_i : 32'd0;
  assign d_ack_o      = pop & head.own_d;
  assign d_error_o    = d_ack_o & m_error_i;
  assign d_data_rd_o  = d_ack_o ? m_data_rd_i : 32'd0;
  assign d_resp_tag_o = d_ack_o ? head.tag : '0;

  // Lock onto a presented-but-unaccepted request so the bus stays stable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (drv_i && !m_accept_i)      state <= LOCK_I;
          else if (drv_d && !m_accept_i) state <= LOCK_D;
        end
        LOCK_I:  if (i_accept_o) state <= IDLE;
        LOCK_D:  if (d_accept_o) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Count consecutive D grants taken while fetch is waiting.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                starve_cnt <= '0;
    else if (!i_rd_i || i_accept_o)           starve_cnt <= '0;
    else if (d_accept_o && starve_cnt != SMAX) starve_cnt <= starve_cnt + 1'b1;
  end

  // Ownership FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Ownership FIFO storage; contents are meaningless while the entry is free.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr] <= push_ent;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
Two-into-one memory port arbiter. Shares a single unified memory bus between the instruction-fetch port and the LSU data port of the core. Tracks outstanding requests in an in-order ownership FIFO and routes each response back to its requester, restoring the D-side tag. D-side has priority, with a starvation limiter protecting fetch.

Parameters:
OUTSTANDING, 4, ownership FIFO depth (power of 2, >=2); max in-flight requests
STARVE_MAX, 4, consecutive accepted D grants allowed while I is pending before I is forced ahead
TAG_W, 11, D-side request/response tag width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
i_rd_i  in  1  fetch read request
i_pc_i  in  32  fetch address
i_accept_o  out  1  fetch request accepted this cycle
i_valid_o  out  1  fetch response valid
i_error_o  out  1  fetch response bus error
i_inst_o  out  32  fetch response data
d_rd_i  in  1  data read request
d_wr_i  in  4  data write byte enables (nonzero = write)
d_addr_i  in  32  data address
d_data_wr_i  in  32  write data
d_req_tag_i  in  TAG_W  request tag
d_accept_o  out  1  data request accepted this cycle
d_ack_o  out  1  data response (reads and writes)
d_error_o  out  1  data response bus error
d_data_rd_o  out  32  read data
d_resp_tag_o  out  TAG_W  tag of the request being acknowledged
m_rd_o  out  1  memory read
m_wr_o  out  4  memory byte write enables
m_addr_o  out  32  memory address
m_data_wr_o  out  32  memory write data
m_accept_i  in  1  memory accepted request
m_ack_i  in  1  memory response, strictly in request order, one per request
m_error_i  in  1  response error
m_data_rd_i  in  32  response data

Behaviour:
- d_req = d_rd_i | (|d_wr_i). Requesters hold their request stable until accept.
- States: IDLE, LOCK_I, LOCK_D. In IDLE, choose a winner combinationally: D if d_req and no starve override; else I if i_rd_i. Starve override = i_rd_i & (starve_cnt == STARVE_MAX).
- Winner drives m_* in the same cycle when FIFO not full. I-side drive: m_rd_o=1, m_wr_o=0, m_addr_o=i_pc_i, m_data_wr_o=0. No winner or FIFO full: m_rd_o=0, m_wr_o=0.
- Driven but m_accept_i=0: go to LOCK_x next cycle. While locked, only that requester is driven until accepted, then return to IDLE. A presented request never changes before acceptance.
- x_accept_o = granted_x & m_accept_i & ~full; combinational, zero latency.
- On acceptance, push {owner, d_req_tag_i} to FIFO; I pushes tag 0.
- starve_cnt: +1 (saturating at STARVE_MAX) on each accepted D request while i_rd_i=1. Cleared on accepted I request, or when i_rd_i=0.
- Response path (combinational): when m_ack_i and FIFO not empty, pop the head.
  - Owner I: i_valid_o=1, i_inst_o=m_data_rd_i, i_error_o=m_error_i.
  - Owner D: d_ack_o=1, d_data_rd_o=m_data_rd_i, d_error_o=m_error_i, d_resp_tag_o=stored tag.
  - Inactive side's valid/ack/error are 0 and data is 0.
- m_ack_i with FIFO empty: dropped, no outputs asserted, no state change.
- Simultaneous push and pop: count unchanged, both pointers advance. Issue is blocked whenever count==OUTSTANDING, even if a pop occurs that cycle.
- Reset: state IDLE, FIFO empty (count 0, pointers 0), starve_cnt 0. All outputs 0 in the reset cycle and after reset with no inputs active. Reset mid-operation discards in-flight ownership; later stale acks are dropped as above.

Test Plan:
- Single fetch: i_rd_i=1, pc=0x80000000, m_accept_i=1 -> i_accept_o=1 same cycle, m_addr_o=0x80000000; m_ack_i with data 0x00000013 two cycles later -> i_valid_o=1, i_inst_o=0x00000013, d_ack_o=0.
- Priority and starvation: i_rd_i and d_rd_i held continuously, m_accept_i=1, acks returned promptly -> 4 D accepts, then 1 I accept, then D resumes; repeating pattern.
- Lock: d_wr_i=0xF, addr 0x80000010, m_accept_i=0 for 3 cycles while i_rd_i rises -> m_* stay on the D write for all 3 cycles; on accept, I is granted the next cycle.
- Tag routing/full: 4 D reads accepted with tags 0x001..0x004, no acks -> 5th request not driven (m_rd_o=0); acks return tags 0x001..0x004 in order. Issue resumes the cycle after the first pop.
- Interleaved I/D with m_error_i on the 2nd ack (a D request) -> d_error_o=1 with the correct tag; i_error_o stays 0.
- Reset with 2 outstanding, then 2 acks -> no i_valid_o or d_ack_o asserted; the next new request completes normally.
